hci_word_datamover: RTL and testbench
=====================================

// Module: hci_word_datamover
// PURPOSE
// - Programmable single-channel word copier sitting between a peripheral config port and one HCI TCDM initiator port.
// - Software programs source, destination and length through the peripheral port, then writes TRIGGER.
// - The block copies LEN data words from SRC to DST, one read then one write per word.
// - evt_o pulses when the copy completes. One instance per interconnect initiator slot (narrow core or wide HWPE).
// PARAMETERS
// ID_WIDTH   8   width of periph request/response id
// DW         32  TCDM data width in bits (multiple of 8)
// AW         32  TCDM byte-address width
// CNT_WIDTH  16  width of LEN register (max words per transfer)
// PORTS
// clk_i            in   1         clock
// rst_ni           in   1         reset, asynchronous, active-low
// test_mode_i      in   1         test mode; no functional effect
// evt_o            out  1         one-cycle completion pulse
// periph_req_i     in   1         config request
// periph_gnt_o     out  1         config grant
// periph_add_i     in   32        config byte address (bits [8:0] decoded)
// periph_wen_i     in   1         1 = read, 0 = write
// periph_be_i      in   4         byte enables (ignored; full-word access)
// periph_data_i    in   32        write data
// periph_id_i      in   ID_WIDTH  request id
// periph_r_data_o  out  32        read data
// periph_r_valid_o out  1         response valid
// periph_r_id_o    out  ID_WIDTH  echoed id
// tcdm_req_o       out  1         TCDM request
// tcdm_gnt_i       in   1         TCDM grant
// tcdm_add_o       out  AW        TCDM byte address
// tcdm_wen_o       out  1         1 = read, 0 = write
// tcdm_data_o      out  DW        write data
// tcdm_be_o        out  DW/8      byte enables; all ones
// tcdm_r_data_i    in   DW        read data
// tcdm_r_valid_i   in   1         read response valid
// tcdm_r_ready_o   out  1         constant 1
// BEHAVIOUR
// - Reset: all outputs 0 except tcdm_r_ready_o=1 and tcdm_be_o=all ones; registers cleared; FSM IDLE.
// - Periph: periph_gnt_o = periph_req_i (combinational).
//   - r_valid asserts exactly 1 cycle after every granted request, reads and writes alike; r_id echoes the id.
//   - r_data = register value for reads, 0 for writes and for unmapped offsets.
// - Register map (add[8:0]):
//   - 0x00 TRIGGER (W): start a copy if IDLE; ignored if busy.
//   - 0x04 STATUS (R): bit0 = busy.
//   - 0x08 SRC: source byte address.
//   - 0x0C DST: destination byte address.
//   - 0x10 LEN: number of words (CNT_WIDTH bits).
//   - 0x14 SOFT_CLEAR (W): abort to IDLE and zero all registers.
//   - Writes to SRC, DST or LEN while busy are ignored.
// - FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
//   - IDLE -TRIGGER & LEN!=0-> RD_REQ. IDLE -TRIGGER & LEN==0-> DONE.
//   - RD_REQ: req=1, wen=1, add=src_ptr; held stable until gnt; on gnt -> RD_WAIT.
//   - RD_WAIT: capture r_data into a one-word buffer on r_valid -> WR_REQ.
//   - WR_REQ: req=1, wen=0, add=dst_ptr, data=buffer; on gnt: pointers += DW/8, count -= 1.
//     If count reaches 0 -> DONE, else -> RD_REQ.
//   - DONE: evt_o=1 for one cycle -> IDLE.
// - Pointers wrap modulo 2^AW.
// - TRIGGER on the DONE cycle is ignored.
// - SOFT_CLEAR mid-transfer drops req the next cycle; a pending read response is discarded.
// - busy = (state != IDLE).
// - Minimum per-word latency with gnt and r_valid immediate: 3 cycles.
// STRUCTURE
// - Package hci_word_datamover_pkg: register offset localparams and the FSM state enum.
// - Sub-module hci_word_datamover_regfile: periph decode, response pipeline, config registers.
// - Top module: FSM, pointers/counter, data buffer.
// TESTING
// - Config readback: write SRC=0x100, DST=0x400, LEN=4; read back each.
//   -> r_valid 1 cycle later, values match, r_id echoed.
// - Copy: SRC=0x0, DST=0x80, LEN=4, TCDM model always grants, r_valid after 1 cycle.
//   -> reads at 0x0,0x4,0x8,0xC and writes at 0x80..0x8C carry the same data; one evt_o pulse.
// - Backpressure: gnt withheld 3 cycles on each request.
//   -> add, wen and data stay stable until gnt; copy still correct.
// - LEN=0 TRIGGER -> no tcdm_req_o; evt_o pulses 2 cycles after the TRIGGER request.
// - Busy guard: TRIGGER, and a write DST=0xFFF, issued mid-copy -> ignored; STATUS reads 1 until done.
// - SOFT_CLEAR mid-copy of LEN=8 -> req drops, STATUS=0, registers read 0, no evt_o.

Source files
------------

// File: rtl/hci_word_datamover_pkg.sv
// Shared definitions for the HCI word datamover.
// - Register offsets of the peripheral configuration port (byte address bits [8:0]).
// - Copy-engine FSM state encoding.
package hci_word_datamover_pkg;

    localparam logic [8:0] REG_TRIGGER    = 9'h000;
    localparam logic [8:0] REG_STATUS     = 9'h004;
    localparam logic [8:0] REG_SRC        = 9'h008;
    localparam logic [8:0] REG_DST        = 9'h00C;
    localparam logic [8:0] REG_LEN        = 9'h010;
    localparam logic [8:0] REG_SOFT_CLEAR = 9'h014;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_e;

endpackage

// File: rtl/hci_word_datamover_regfile.sv
// Peripheral-side register file of the HCI word datamover.
// - Grants every request combinationally and answers one cycle later with
//   r_valid, the echoed id and read data (zero for writes and unmapped offsets).
// - Holds SRC, DST and LEN; writes to them are dropped while the engine is busy.
// - Emits single-cycle trigger / soft-clear strobes decoded from write requests.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   periph_*                 config port request/response
//   busy_i                   engine busy (blocks config writes, read via STATUS)
//   src_o, dst_o, len_o      programmed copy parameters
//   trigger_o, soft_clear_o  command strobes, valid in the request cycle
module hci_word_datamover_regfile
    import hci_word_datamover_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = 8,
    parameter int unsigned AW        = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 periph_req_i,
    output logic                 periph_gnt_o,
    input  logic [8:0]           periph_add_i,
    input  logic                 periph_wen_i,
    input  logic [31:0]          periph_data_i,
    input  logic [ID_WIDTH-1:0]  periph_id_i,
    output logic [31:0]          periph_r_data_o,
    output logic                 periph_r_valid_o,
    output logic [ID_WIDTH-1:0]  periph_r_id_o,
    input  logic                 busy_i,
    output logic [AW-1:0]        src_o,
    output logic [AW-1:0]        dst_o,
    output logic [CNT_WIDTH-1:0] len_o,
    output logic                 trigger_o,
    output logic                 soft_clear_o
);

    logic                 wr_en;
    logic                 rd_en;
    logic [31:0]          rd_data;
    logic [AW-1:0]        src_q;
    logic [AW-1:0]        dst_q;
    logic [CNT_WIDTH-1:0] len_q;

    assign periph_gnt_o = periph_req_i;
    assign wr_en        = periph_req_i & ~periph_wen_i;
    assign rd_en        = periph_req_i &  periph_wen_i;
    assign trigger_o    = wr_en & (periph_add_i == REG_TRIGGER);
    assign soft_clear_o = wr_en & (periph_add_i == REG_SOFT_CLEAR);

    assign src_o = src_q;
    assign dst_o = dst_q;
    assign len_o = len_q;

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            case (periph_add_i)
                REG_STATUS: rd_data = 32'(busy_i);
                REG_SRC:    rd_data = 32'(src_q);
                REG_DST:    rd_data = 32'(dst_q);
                REG_LEN:    rd_data = 32'(len_q);
                default:    rd_data = '0;
            endcase
        end
    end

    // Response pipeline: exactly one cycle behind every granted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            periph_r_valid_o <= 1'b0;
            periph_r_data_o  <= '0;
            periph_r_id_o    <= '0;
        end else begin
            periph_r_valid_o <= periph_req_i;
            periph_r_data_o  <= rd_data;
            if (periph_req_i) begin
                periph_r_id_o <= periph_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else if (soft_clear_o) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else if (wr_en && !busy_i) begin
            case (periph_add_i)
                REG_SRC: src_q <= AW'(periph_data_i);
                REG_DST: dst_q <= AW'(periph_data_i);
                REG_LEN: len_q <= CNT_WIDTH'(periph_data_i);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hci_word_datamover.sv
// HCI word datamover: copies LEN words from SRC to DST over one TCDM
// initiator port, one read followed by one write per word, and pulses evt_o
// once the copy is finished.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   test_mode_i       no functional effect
//   evt_o             one-cycle completion pulse
//   periph_*          config port (register file, see regfile header)
//   tcdm_*            TCDM initiator port; be is all ones, r_ready is constant 1
module hci_word_datamover
    import hci_word_datamover_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = 8,
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_mode_i,
    output logic                evt_o,
    input  logic                periph_req_i,
    output logic                periph_gnt_o,
    input  logic [31:0]         periph_add_i,
    input  logic                periph_wen_i,
    input  logic [3:0]          periph_be_i,
    input  logic [31:0]         periph_data_i,
    input  logic [ID_WIDTH-1:0] periph_id_i,
    output logic [31:0]         periph_r_data_o,
    output logic                periph_r_valid_o,
    output logic [ID_WIDTH-1:0] periph_r_id_o,
    output logic                tcdm_req_o,
    input  logic                tcdm_gnt_i,
    output logic [AW-1:0]       tcdm_add_o,
    output logic                tcdm_wen_o,
    output logic [DW-1:0]       tcdm_data_o,
    output logic [DW/8-1:0]     tcdm_be_o,
    input  logic [DW-1:0]       tcdm_r_data_i,
    input  logic                tcdm_r_valid_i,
    output logic                tcdm_r_ready_o
);

    localparam logic [AW-1:0] WORD_BYTES = AW'(DW / 8);

    state_e               state_q, state_d;
    logic [AW-1:0]        src_ptr_q;
    logic [AW-1:0]        dst_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [DW-1:0]        data_buf_q;
    logic                 evt_q;

    logic [AW-1:0]        cfg_src;
    logic [AW-1:0]        cfg_dst;
    logic [CNT_WIDTH-1:0] cfg_len;
    logic                 trigger;
    logic                 soft_clear;
    logic                 busy;

    logic                 unused_ok;
    assign unused_ok = ^{test_mode_i, periph_be_i, periph_add_i[31:9]};

    assign busy           = (state_q != IDLE);
    assign evt_o          = evt_q;
    assign tcdm_be_o      = '1;
    assign tcdm_r_ready_o = 1'b1;

    hci_word_datamover_regfile #(
        .ID_WIDTH  (ID_WIDTH),
        .AW        (AW),
        .CNT_WIDTH (CNT_WIDTH)
    ) i_regfile (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .periph_req_i     (periph_req_i),
        .periph_gnt_o     (periph_gnt_o),
        .periph_add_i     (periph_add_i[8:0]),
        .periph_wen_i     (periph_wen_i),
        .periph_data_i    (periph_data_i),
        .periph_id_i      (periph_id_i),
        .periph_r_data_o  (periph_r_data_o),
        .periph_r_valid_o (periph_r_valid_o),
        .periph_r_id_o    (periph_r_id_o),
        .busy_i           (busy),
        .src_o            (cfg_src),
        .dst_o            (cfg_dst),
        .len_o            (cfg_len),
        .trigger_o        (trigger),
        .soft_clear_o     (soft_clear)
    );

    // Request outputs depend on the current state only, so they stay stable
    // for the whole cycle until the grant arrives.
    always_comb begin
        state_d     = state_q;
        tcdm_req_o  = 1'b0;
        tcdm_wen_o  = 1'b0;
        tcdm_add_o  = '0;
        tcdm_data_o = '0;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = (cfg_len == '0) ? DONE : RD_REQ;
                end
            end
            RD_REQ: begin
                tcdm_req_o = 1'b1;
                tcdm_wen_o = 1'b1;
                tcdm_add_o = src_ptr_q;
                if (tcdm_gnt_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (tcdm_r_valid_i) begin
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                tcdm_req_o  = 1'b1;
                tcdm_wen_o  = 1'b0;
                tcdm_add_o  = dst_ptr_q;
                tcdm_data_o = data_buf_q;
                if (tcdm_gnt_i) begin
                    state_d = (count_q == CNT_WIDTH'(1)) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything; a read still in flight lands in IDLE
        // and is ignored there.
        if (soft_clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            count_q    <= '0;
            data_buf_q <= '0;
            evt_q      <= 1'b0;
        end else if (soft_clear) begin
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            count_q    <= '0;
            data_buf_q <= '0;
            evt_q      <= 1'b0;
        end else begin
            evt_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        src_ptr_q <= cfg_src;
                        dst_ptr_q <= cfg_dst;
                        count_q   <= cfg_len;
                    end
                end
                RD_WAIT: begin
                    if (tcdm_r_valid_i) begin
                        data_buf_q <= tcdm_r_data_i;
                    end
                end
                WR_REQ: begin
                    if (tcdm_gnt_i) begin
                        src_ptr_q <= src_ptr_q + WORD_BYTES;
                        dst_ptr_q <= dst_ptr_q + WORD_BYTES;
                        count_q   <= count_q - CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hci_word_datamover.sv
module tb_hci_word_datamover;

    localparam int ID_WIDTH  = 8;
    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int CNT_WIDTH = 16;

    localparam logic [8:0] O_TRIG  = 9'h000;
    localparam logic [8:0] O_STAT  = 9'h004;
    localparam logic [8:0] O_SRC   = 9'h008;
    localparam logic [8:0] O_DST   = 9'h00C;
    localparam logic [8:0] O_LEN   = 9'h010;
    localparam logic [8:0] O_CLEAR = 9'h014;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                test_mode_i;
    logic                evt_o;
    logic                periph_req_i;
    logic                periph_gnt_o;
    logic [31:0]         periph_add_i;
    logic                periph_wen_i;
    logic [3:0]          periph_be_i;
    logic [31:0]         periph_data_i;
    logic [ID_WIDTH-1:0] periph_id_i;
    logic [31:0]         periph_r_data_o;
    logic                periph_r_valid_o;
    logic [ID_WIDTH-1:0] periph_r_id_o;
    logic                tcdm_req_o;
    logic                tcdm_gnt_i;
    logic [AW-1:0]       tcdm_add_o;
    logic                tcdm_wen_o;
    logic [DW-1:0]       tcdm_data_o;
    logic [DW/8-1:0]     tcdm_be_o;
    logic [DW-1:0]       tcdm_r_data_i;
    logic                tcdm_r_valid_i;
    logic                tcdm_r_ready_o;

    always #5 clk = ~clk;

    hci_word_datamover #(
        .ID_WIDTH  (ID_WIDTH),
        .DW        (DW),
        .AW        (AW),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .test_mode_i      (test_mode_i),
        .evt_o            (evt_o),
        .periph_req_i     (periph_req_i),
        .periph_gnt_o     (periph_gnt_o),
        .periph_add_i     (periph_add_i),
        .periph_wen_i     (periph_wen_i),
        .periph_be_i      (periph_be_i),
        .periph_data_i    (periph_data_i),
        .periph_id_i      (periph_id_i),
        .periph_r_data_o  (periph_r_data_o),
        .periph_r_valid_o (periph_r_valid_o),
        .periph_r_id_o    (periph_r_id_o),
        .tcdm_req_o       (tcdm_req_o),
        .tcdm_gnt_i       (tcdm_gnt_i),
        .tcdm_add_o       (tcdm_add_o),
        .tcdm_wen_o       (tcdm_wen_o),
        .tcdm_data_o      (tcdm_data_o),
        .tcdm_be_o        (tcdm_be_o),
        .tcdm_r_data_i    (tcdm_r_data_i),
        .tcdm_r_valid_i   (tcdm_r_valid_i),
        .tcdm_r_ready_o   (tcdm_r_ready_o)
    );

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        int          cyc;
    } resp_t;

    txn_t  tcdm_q[$];
    resp_t resp_q[$];
    int    evt_q[$];

    int   n_cmp     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   evt_count = 0;
    int   gnt_delay = 0;
    bit   chk_stable = 1'b0;
    bit   no_req     = 1'b0;
    logic [7:0]  next_id = 8'h10;
    logic [31:0] mem [0:1023];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // TCDM target: grant after gnt_delay stalled cycles, read data one cycle after grant.
    initial begin : tcdm_model
        bit          rd_pend;
        logic [31:0] rd_addr;
        int          wait_cnt;
        rd_pend  = 1'b0;
        rd_addr  = '0;
        wait_cnt = 0;
        tcdm_gnt_i     = 1'b0;
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
        forever begin
            @(posedge clk);
            #1;
            tcdm_r_valid_i = rd_pend;
            tcdm_r_data_i  = rd_pend ? mem[rd_addr[11:2]] : '0;
            if (tcdm_req_o && rst_ni) begin
                if (wait_cnt >= gnt_delay) begin
                    tcdm_gnt_i = 1'b1;
                    wait_cnt   = 0;
                end else begin
                    tcdm_gnt_i = 1'b0;
                    wait_cnt++;
                end
            end else begin
                tcdm_gnt_i = 1'b0;
            end
            rd_pend = tcdm_req_o && tcdm_gnt_i && tcdm_wen_o;
            rd_addr = tcdm_add_o;
            if (tcdm_req_o && tcdm_gnt_i && !tcdm_wen_o) mem[tcdm_add_o[11:2]] = tcdm_data_o;
        end
    end

    // Monitor / scoreboard: compares whatever the DUT presents against queued expectations.
    initial begin : monitor
        bit          prev_stall;
        logic [31:0] prev_add;
        logic        prev_wen;
        logic [31:0] prev_data;
        txn_t        t;
        resp_t       r;
        int          e;
        prev_stall = 1'b0;
        prev_add   = '0;
        prev_wen   = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (tcdm_req_o && tcdm_gnt_i) begin
                    if (tcdm_q.size() == 0) begin
                        flag("tcdm_unexpected_txn");
                    end else begin
                        t = tcdm_q.pop_front();
                        chk("tcdm_wen", 64'(tcdm_wen_o), 64'(t.wen));
                        chk("tcdm_add", 64'(tcdm_add_o), 64'(t.add));
                        if (!t.wen) chk("tcdm_wdata", 64'(tcdm_data_o), 64'(t.data));
                    end
                end
                if (no_req) chk("tcdm_req_quiet", 64'(tcdm_req_o), 64'(0));
                if (chk_stable && prev_stall) begin
                    chk("stall_req_held", 64'(tcdm_req_o), 64'(1));
                    chk("stall_add_held", 64'(tcdm_add_o), 64'(prev_add));
                    chk("stall_wen_held", 64'(tcdm_wen_o), 64'(prev_wen));
                    chk("stall_data_held", 64'(tcdm_data_o), 64'(prev_data));
                end
                prev_stall = tcdm_req_o && !tcdm_gnt_i;
                prev_add   = tcdm_add_o;
                prev_wen   = tcdm_wen_o;
                prev_data  = tcdm_data_o;

                if (periph_r_valid_o) begin
                    if (resp_q.size() == 0) begin
                        flag("periph_unexpected_rvalid");
                    end else begin
                        r = resp_q.pop_front();
                        chk("periph_rdata", 64'(periph_r_data_o), 64'(r.data));
                        chk("periph_rid", 64'(periph_r_id_o), 64'(r.id));
                        chk("periph_rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    end
                end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
                    r = resp_q.pop_front();
                    flag("periph_rvalid_missing");
                end

                if (evt_o) begin
                    evt_count++;
                    if (evt_q.size() == 0) begin
                        flag("evt_unexpected");
                    end else begin
                        e = evt_q.pop_front();
                        chk("evt_cycle", 64'(cyc), 64'(e));
                    end
                end else if (evt_q.size() != 0 && evt_q[0] < cyc) begin
                    e = evt_q.pop_front();
                    flag("evt_missing");
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preg(input bit wen, input logic [8:0] off, input logic [31:0] data,
                        input logic [31:0] exp);
        resp_t r;
        periph_req_i  = 1'b1;
        periph_wen_i  = wen;
        periph_add_i  = {23'h0, off};
        periph_data_i = data;
        periph_id_i   = next_id;
        r.data = exp;
        r.id   = next_id;
        r.cyc  = cyc + 1;
        resp_q.push_back(r);
        next_id = next_id + 8'd1;
        tick(1);
        periph_req_i  = 1'b0;
        periph_wen_i  = 1'b0;
        periph_data_i = '0;
    endtask

    task automatic wr(input logic [8:0] off, input logic [31:0] data);
        preg(1'b0, off, data, 32'h0);
    endtask

    task automatic rd(input logic [8:0] off, input logic [31:0] exp);
        preg(1'b1, off, 32'h0, exp);
    endtask

    // Source memory holds 0x1000_0000 + byte address, so each written word is predictable.
    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        txn_t t;
        for (int k = 0; k < len; k++) begin
            t.wen = 1'b1; t.add = src + 32'(4 * k); t.data = '0;
            tcdm_q.push_back(t);
            t.wen = 1'b0; t.add = dst + 32'(4 * k); t.data = 32'h1000_0000 + src + 32'(4 * k);
            tcdm_q.push_back(t);
        end
    endtask

    task automatic wait_evt(input int start, input int budget);
        int i;
        i = 0;
        while (evt_count == start && i < budget) begin
            tick(1);
            i++;
        end
        chk("evt_seen", 64'(evt_count > start), 64'(1));
    endtask

    initial begin : stimulus
        int   c;
        int   es;
        txn_t t;
        rst_ni        = 1'b0;
        test_mode_i   = 1'b0;
        periph_req_i  = 1'b0;
        periph_add_i  = '0;
        periph_wen_i  = 1'b0;
        periph_be_i   = 4'hF;
        periph_data_i = '0;
        periph_id_i   = '0;
        #12;
        chk("rst_evt", 64'(evt_o), 64'(0));
        chk("rst_pgnt", 64'(periph_gnt_o), 64'(0));
        chk("rst_rvalid", 64'(periph_r_valid_o), 64'(0));
        chk("rst_rdata", 64'(periph_r_data_o), 64'(0));
        chk("rst_rid", 64'(periph_r_id_o), 64'(0));
        chk("rst_treq", 64'(tcdm_req_o), 64'(0));
        chk("rst_tadd", 64'(tcdm_add_o), 64'(0));
        chk("rst_twen", 64'(tcdm_wen_o), 64'(0));
        chk("rst_tdata", 64'(tcdm_data_o), 64'(0));
        chk("rst_tbe", 64'(tcdm_be_o), 64'h0F);
        chk("rst_rready", 64'(tcdm_r_ready_o), 64'(1));
        @(negedge clk);
        rst_ni = 1'b1;
        tick(2);

        // Config readback, unmapped and write-only offsets read as zero
        wr(O_SRC, 32'h100);
        wr(O_DST, 32'h400);
        wr(O_LEN, 32'h4);
        rd(O_SRC, 32'h100);
        rd(O_DST, 32'h400);
        rd(O_LEN, 32'h4);
        rd(O_STAT, 32'h0);
        rd(9'h018, 32'h0);
        rd(O_TRIG, 32'h0);
        tick(2);

        // Plain copy, zero-wait TCDM: 3 cycles per word, evt one cycle after DONE
        wr(O_SRC, 32'h0);
        wr(O_DST, 32'h80);
        wr(O_LEN, 32'h4);
        c  = cyc;
        es = evt_count;
        push_copy(32'h0, 32'h80, 4);
        evt_q.push_back(c + 14);
        wr(O_TRIG, 32'h1);
        wait_evt(es, 40);
        rd(O_STAT, 32'h0);
        tick(2);

        // Backpressure: 3 stalled cycles on every request
        gnt_delay  = 3;
        chk_stable = 1'b1;
        wr(O_SRC, 32'h200);
        wr(O_DST, 32'h300);
        wr(O_LEN, 32'h3);
        c  = cyc;
        es = evt_count;
        push_copy(32'h200, 32'h300, 3);
        evt_q.push_back(c + 29);
        wr(O_TRIG, 32'h1);
        wait_evt(es, 80);
        tick(2);
        chk_stable = 1'b0;
        gnt_delay  = 0;

        // LEN = 0: no TCDM traffic, evt two cycles after the trigger request
        wr(O_LEN, 32'h0);
        no_req = 1'b1;
        c  = cyc;
        es = evt_count;
        evt_q.push_back(c + 2);
        wr(O_TRIG, 32'h1);
        wait_evt(es, 10);
        tick(3);
        no_req = 1'b0;

        // Busy guard: re-trigger and DST write mid-copy ignored; trigger on DONE ignored
        wr(O_SRC, 32'h40);
        wr(O_DST, 32'h500);
        wr(O_LEN, 32'h4);
        c = cyc;
        push_copy(32'h40, 32'h500, 4);
        evt_q.push_back(c + 14);
        wr(O_TRIG, 32'h1);      // c
        wr(O_TRIG, 32'h1);      // c+1
        wr(O_DST, 32'hFFF);     // c+2
        rd(O_STAT, 32'h1);      // c+3
        rd(O_DST, 32'h500);     // c+4
        tick(7);
        rd(O_STAT, 32'h1);      // c+12, last write beat
        wr(O_TRIG, 32'h1);      // c+13, DONE cycle
        rd(O_STAT, 32'h0);      // c+14
        rd(O_DST, 32'h500);     // c+15
        tick(6);

        // Soft clear during the second read of an 8-word copy
        wr(O_SRC, 32'h600);
        wr(O_DST, 32'h700);
        wr(O_LEN, 32'h8);
        t.wen = 1'b1; t.add = 32'h600; t.data = '0;           tcdm_q.push_back(t);
        t.wen = 1'b0; t.add = 32'h700; t.data = 32'h1000_0600; tcdm_q.push_back(t);
        t.wen = 1'b1; t.add = 32'h604; t.data = '0;           tcdm_q.push_back(t);
        wr(O_TRIG, 32'h1);      // c
        tick(3);
        wr(O_CLEAR, 32'h1);     // c+4, RD_REQ granted this cycle
        no_req = 1'b1;
        rd(O_STAT, 32'h0);
        rd(O_SRC, 32'h0);
        rd(O_DST, 32'h0);
        rd(O_LEN, 32'h0);
        tick(20);
        no_req = 1'b0;

        tick(3);
        chk("tcdm_q_drained", 64'(tcdm_q.size()), 64'(0));
        chk("resp_q_drained", 64'(resp_q.size()), 64'(0));
        chk("evt_q_drained", 64'(evt_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
